// File: rtl/pan_sched_ctl.sv
// Pixel-panning sequencer: stages panning writes to frame boundaries, forces zero
// panning after a line-compare split, and blanks the shifter while its chain refills.
module pan_sched_ctl #(
    parameter int unsigned SETTLE_LEN = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       ar13_wr,
    input  logic [3:0] ar13_din,
    input  logic       pp_mode,
    input  logic       vsync_start,
    input  logic       line_cmp_hit,
    output logic [3:0] pp_ctl,
    output logic       pan_blank,
    output logic       pend_valid,
    output logic [3:0] pp_active
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_LEN);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] settle_cnt_r;
    logic [3:0] settle_cnt_nxt_s;
    logic [3:0] staging_r;
    logic       pend_valid_r;
    logic [3:0] pp_active_r;
    logic       split_force_r;
    logic [3:0] pp_ctl_r;
    logic       pan_blank_r;

    logic [3:0] pp_active_nxt_s;
    logic       split_force_nxt_s;
    logic [3:0] pp_ctl_nxt_s;
    logic       pp_change_s;
    logic       pan_blank_nxt_s;

    // Next applied/forced panning values; pulses act on every clk, not just clk_en.
    always_comb begin
        pp_active_nxt_s   = pp_active_r;
        split_force_nxt_s = split_force_r;
        if (vsync_start && pend_valid_r) begin
            pp_active_nxt_s = staging_r;
        end else begin
            pp_active_nxt_s = pp_active_r;
        end
        // The frame boundary outranks a split landing in the same cycle.
        if (vsync_start) begin
            split_force_nxt_s = 1'b0;
        end else if (line_cmp_hit && pp_mode) begin
            split_force_nxt_s = 1'b1;
        end else begin
            split_force_nxt_s = split_force_r;
        end
        pp_ctl_nxt_s = split_force_nxt_s ? 4'h0 : pp_active_nxt_s;
        pp_change_s  = (pp_ctl_nxt_s != pp_ctl_r);
    end

    // Staging register, pending flag and applied panning registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            staging_r     <= 4'h0;
            pend_valid_r  <= 1'b0;
            pp_active_r   <= 4'h0;
            split_force_r <= 1'b0;
            pp_ctl_r      <= 4'h0;
        end else begin
            if (ar13_wr) begin
                staging_r    <= ar13_din;
                pend_valid_r <= 1'b1;
            end else if (vsync_start) begin
                pend_valid_r <= 1'b0;
            end
            pp_active_r   <= pp_active_nxt_s;
            split_force_r <= split_force_nxt_s;
            pp_ctl_r      <= pp_ctl_nxt_s;
        end
    end

    // Settle FSM state register and registered blank output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            settle_cnt_r <= 4'h0;
            pan_blank_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            settle_cnt_r <= settle_cnt_nxt_s;
            pan_blank_r  <= pan_blank_nxt_s;
        end
    end

    // Settle FSM next state: any change reloads the full settle window.
    always_comb begin
        state_nxt_s      = state_r;
        settle_cnt_nxt_s = settle_cnt_r;
        if (pp_change_s) begin
            state_nxt_s      = SETTLE;
            settle_cnt_nxt_s = SETTLE_INIT;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s      = IDLE;
                    settle_cnt_nxt_s = 4'h0;
                end
                SETTLE: begin
                    if (clk_en) begin
                        if (settle_cnt_r == 4'd1) begin
                            state_nxt_s      = IDLE;
                            settle_cnt_nxt_s = 4'h0;
                        end else begin
                            state_nxt_s      = SETTLE;
                            settle_cnt_nxt_s = settle_cnt_r - 4'd1;
                        end
                    end else begin
                        state_nxt_s      = SETTLE;
                        settle_cnt_nxt_s = settle_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s      = IDLE;
                    settle_cnt_nxt_s = 4'h0;
                end
            endcase
        end
    end

    // Settle FSM output decode.
    always_comb begin
        pan_blank_nxt_s = 1'b0;
        case (state_nxt_s)
            SETTLE:  pan_blank_nxt_s = 1'b1;
            IDLE:    pan_blank_nxt_s = 1'b0;
            default: pan_blank_nxt_s = 1'b0;
        endcase
    end

    assign pp_ctl     = pp_ctl_r;
    assign pan_blank  = pan_blank_r;
    assign pend_valid = pend_valid_r;
    assign pp_active  = pp_active_r;

endmodule

// File: tb/tb_pan_sched_ctl.sv
// Directed bench for pan_sched_ctl: per-cycle vector table plus hand-written
// sequences for clk_en gating, retrigger, same-value rewrite and mid-settle reset.
module tb_pan_sched_ctl;

    localparam int unsigned SETTLE_LEN = 9;

    if (SETTLE_LEN < 1 || SETTLE_LEN > 15) begin : g_len_chk
        $fatal(1, "SETTLE_LEN out of range 1..15");
    end

    logic       clk;
    logic       reset;
    logic       clk_en;
    logic       ar13_wr;
    logic [3:0] ar13_din;
    logic       pp_mode;
    logic       vsync_start;
    logic       line_cmp_hit;
    logic [3:0] pp_ctl;
    logic       pan_blank;
    logic       pend_valid;
    logic [3:0] pp_active;

    int n_checks = 0;
    int n_fail   = 0;

    pan_sched_ctl #(.SETTLE_LEN(SETTLE_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .ar13_wr      (ar13_wr),
        .ar13_din     (ar13_din),
        .pp_mode      (pp_mode),
        .vsync_start  (vsync_start),
        .line_cmp_hit (line_cmp_hit),
        .pp_ctl       (pp_ctl),
        .pan_blank    (pan_blank),
        .pend_valid   (pend_valid),
        .pp_active    (pp_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       wr;
        logic [3:0] din;
        logic       mode;
        logic       vs;
        logic       lch;
        logic [3:0] e_ctl;
        logic       e_blank;
        logic       e_pend;
        logic [3:0] e_act;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic wr, input logic [3:0] din,
                        input logic mode, input logic vs, input logic lch);
        reset        = rst;
        clk_en       = en;
        ar13_wr      = wr;
        ar13_din     = din;
        pp_mode      = mode;
        vsync_start  = vs;
        line_cmp_hit = lch;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rst, input logic wr, input logic [3:0] din, input logic mode,
                        input logic vs, input logic lch, input logic [3:0] ctl, input logic blank,
                        input logic pend, input logic [3:0] act);
        vec_t v;
        v.rst = rst; v.en = 1'b1; v.wr = wr; v.din = din; v.mode = mode; v.vs = vs; v.lch = lch;
        v.e_ctl = ctl; v.e_blank = blank; v.e_pend = pend; v.e_act = act;
        vecs.push_back(v);
    endtask

    // Idle cycles during a settle window: n-1 blanked cycles, then the release cycle.
    task automatic push_settle(input logic mode, input logic [3:0] ctl, input logic pend, input logic [3:0] act);
        for (int k = 0; k < SETTLE_LEN - 1; k++) push(1'b0, 1'b0, 4'h0, mode, 1'b0, 1'b0, ctl, 1'b1, pend, act);
        push(1'b0, 1'b0, 4'h0, mode, 1'b0, 1'b0, ctl, 1'b0, pend, act);
    endtask

    initial begin
        int tot_en;
        bit lch_done;
        logic en_s;

        reset = 1'b1; clk_en = 1'b1; ar13_wr = 1'b0; ar13_din = 4'h0;
        pp_mode = 1'b0; vsync_start = 1'b0; line_cmp_hit = 1'b0;

        // rst wr din mode vs lch | ctl blank pend act
        push(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        push(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        for (int k = 0; k < 19; k++) push(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        push(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 4'h5);
        push_settle(1'b0, 4'h5, 1'b0, 4'h5);
        // last write wins; write coincident with the boundary is deferred one frame
        push(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 4'h5);
        push(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 4'h5);
        push(1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 4'h7);
        push_settle(1'b0, 4'h7, 1'b1, 4'h7);
        push(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 4'h2);
        push_settle(1'b0, 4'h2, 1'b0, 4'h2);
        // split force with pp_mode=1, then release at boundary, then pp_mode=0 ignored
        push(1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 4'h2);
        push(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 4'h6);
        push_settle(1'b0, 4'h6, 1'b0, 4'h6);
        push(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h6);
        push_settle(1'b1, 4'h0, 1'b0, 4'h6);
        push(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 4'h6);
        push_settle(1'b1, 4'h6, 1'b0, 4'h6);
        push(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 4'h6);
        push(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 4'h6);
        // simultaneous line compare and vsync: boundary wins
        push(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1, 4'h6);
        push(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 4'h4);
        push_settle(1'b0, 4'h4, 1'b0, 4'h4);
        push(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 4'h4);
        push(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 4'h4);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].din, vecs[i].mode, vecs[i].vs, vecs[i].lch);
            check("pp_ctl", i, pp_ctl, vecs[i].e_ctl);
            check("pan_blank", i, {3'b000, pan_blank}, {3'b000, vecs[i].e_blank});
            check("pend_valid", i, {3'b000, pend_valid}, {3'b000, vecs[i].e_pend});
            check("pp_active", i, pp_active, vecs[i].e_act);
        end

        // clk_en every 4th clk; split retrigger after 3 enables extends the blank to 12 enables
        step(1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
        check("gate_pend", 0, {3'b000, pend_valid}, 4'h1);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("gate_ctl", 0, pp_ctl, 4'h9);
        check("gate_blank0", 0, {3'b000, pan_blank}, 4'h1);
        tot_en = 0;
        lch_done = 1'b0;
        for (int c = 0; c < 64 && tot_en < 12; c++) begin
            en_s = ((c % 4) == 3);
            if (tot_en == 3 && !lch_done && !en_s) begin
                step(1'b0, en_s, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
                lch_done = 1'b1;
            end else begin
                step(1'b0, en_s, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            end
            if (en_s) tot_en++;
            check("gate_blank", c, {3'b000, pan_blank}, (tot_en < 12) ? 4'h1 : 4'h0);
        end
        check("gate_enables", 0, 4'(tot_en), 4'd12);
        check("gate_split_ctl", 0, pp_ctl, 4'h0);

        // boundary clears the split; then rewriting the applied value causes no blank
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("unsplit_ctl", 0, pp_ctl, 4'h9);
        check("unsplit_blank", 0, {3'b000, pan_blank}, 4'h1);
        for (int k = 0; k < SETTLE_LEN; k++) step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("unsplit_release", 0, {3'b000, pan_blank}, 4'h0);
        step(1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("same_ctl", 0, pp_ctl, 4'h9);
        check("same_blank", 0, {3'b000, pan_blank}, 4'h0);
        check("same_pend", 0, {3'b000, pend_valid}, 4'h0);

        // reset during SETTLE with a pending write
        step(1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        check("pre_rst_blank", 0, {3'b000, pan_blank}, 4'h1);
        check("pre_rst_pend", 0, {3'b000, pend_valid}, 4'h1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("rst_ctl", 0, pp_ctl, 4'h0);
        check("rst_blank", 0, {3'b000, pan_blank}, 4'h0);
        check("rst_pend", 0, {3'b000, pend_valid}, 4'h0);
        check("rst_act", 0, pp_active, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("post_rst_ctl", 0, pp_ctl, 4'h0);
        check("post_rst_blank", 0, {3'b000, pan_blank}, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("post_rst_blank2", 0, {3'b000, pan_blank}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
